// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//
// Receives a program image as a byte stream and writes it into instruction
// memory as big-endian 32-bit words. The core is held in reset for the whole
// load and is released only after the XOR checksum of the payload matches.
//
// Image: CNT_HI, CNT_LO (word count N), N*4 payload bytes MSB first, then one
// checksum byte (XOR of the payload bytes only).
//
// Ports:
//   clock       system clock, rising edge
//   reset       asynchronous active-low reset
//   rx_data     stream byte
//   rx_valid    rx_data is valid
//   rx_ready    loader can accept a byte
//   imem_we     one-cycle instruction memory write strobe (registered)
//   imem_addr   word address of the write (registered)
//   imem_wdata  instruction word to write (registered)
//   cpu_reset   active-low core reset; high only once the image is verified
//   done        image loaded and verified
//   error       image rejected (oversize count or checksum mismatch)
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    // Memory capacity in words; a count above this is rejected.
    localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;      // word count, then remaining words
    logic [1:0]            bcnt_q, bcnt_d;    // byte position within the word
    logic [23:0]           asm_q, asm_d;      // first three bytes of the word
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic                  accept;
    logic [31:0]           count_full;

    assign accept     = rx_valid && rx_ready;
    assign count_full = {16'd0, cnt_q[15:8], rx_data};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_CNT_HI;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        // The address holds through the write cycle and advances on the
        // edge that ends it.
        addr_d  = we_q ? addr_q + 1'b1 : addr_q;

        unique case (state_q)
            S_CNT_HI: begin
                if (accept) begin
                    cnt_d   = {rx_data, 8'h00};
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (accept) begin
                    cnt_d = {cnt_q[15:8], rx_data};
                    if (count_full > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (count_full == 32'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_d  = {asm_q[15:0], rx_data};
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {asm_q, rx_data};
                        cnt_d   = cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? S_RUN : S_ERROR;
                end
            end
            default: begin
                // RUN and ERROR are terminal until reset.
            end
        endcase
    end

    assign rx_ready   = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
    assign done       = (state_q == S_RUN);
    assign cpu_reset  = (state_q == S_RUN);
    assign error      = (state_q == S_ERROR);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: directed and randomized images checked
// against an image-level reference model.
module tb_imem_boot_loader;

    localparam int AW = 8;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        int          addr;
        logic [31:0] data;
        int          c;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_reset;
    logic          done;
    logic          error;

    imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observed activity, sampled mid-cycle.
    wr_t wq[$];
    int  acc_cyc[$];
    int  end_cyc = -1;
    int  cpu_bad = 0;

    always @(negedge clock) begin
        if (imem_we) wq.push_back('{addr: int'(imem_addr), data: imem_wdata, c: cyc});
        if ((done || error) && end_cyc < 0) end_cyc = cyc;
        if (cpu_reset && !done) cpu_bad++;
    end

    // Reference model results.
    logic [31:0] exp_w[$];
    int          exp_acc;
    bit          exp_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Decode an image by its format rules: word count, words, checksum.
    task automatic model(input bq_t img);
        int n;
        logic [7:0] x;
        exp_w.delete();
        n = int'({img[0], img[1]});
        if (n > (1 << AW)) begin
            exp_acc  = 2;
            exp_done = 1'b0;
            return;
        end
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            exp_w.push_back({img[2+4*k], img[3+4*k], img[4+4*k], img[5+4*k]});
            x = x ^ img[2+4*k] ^ img[3+4*k] ^ img[4+4*k] ^ img[5+4*k];
        end
        exp_acc  = 3 + 4 * n;
        exp_done = (img[2+4*n] == x);
    endtask

    // Called at a negedge; presents bytes, stops once a byte is refused.
    task automatic drive(input bq_t img, input int gapmax, input int limit);
        int g;
        for (int i = 0; i < limit && i < img.size(); i++) begin
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) begin
                rx_valid = 1'b0;
                @(negedge clock);
            end
            rx_valid = 1'b1;
            rx_data  = img[i];
            if (!rx_ready) begin
                @(negedge clock);
                break;
            end
            acc_cyc.push_back(cyc);
            @(negedge clock);
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_rx_ready", rx_ready, 1'b1);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_imem_addr", imem_addr, '0);
        check("rst_imem_wdata", imem_wdata, 32'h0);
        check("rst_cpu_reset", cpu_reset, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
    endtask

    // Called at a negedge; asserts reset mid-cycle and checks outputs at once.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1 check_reset_vals();
        wq.delete();
        acc_cyc.delete();
        end_cyc = -1;
        cpu_bad = 0;
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic run_image(input bq_t img, input int gapmax);
        int nw;
        model(img);
        drive(img, gapmax, img.size());
        repeat (3) @(negedge clock);
        check("accepted", acc_cyc.size(), exp_acc);
        check("nwrites", wq.size(), exp_w.size());
        nw = (wq.size() < exp_w.size()) ? wq.size() : exp_w.size();
        for (int i = 0; i < nw; i++) begin
            check("waddr", wq[i].addr, i);
            check("wdata", wq[i].data, exp_w[i]);
            if (5 + 4 * i < acc_cyc.size()) check("wcyc", wq[i].c, acc_cyc[5+4*i] + 1);
        end
        check("done", done, exp_done);
        check("error", error, !exp_done);
        check("cpu_reset", cpu_reset, exp_done);
        check("rx_ready_end", rx_ready, 1'b0);
        check("imem_we_end", imem_we, 1'b0);
        check("cpu_early", cpu_bad, 0);
        if (acc_cyc.size() >= exp_acc) check("end_cyc", end_cyc, acc_cyc[exp_acc-1] + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t basic, img;
        int n;
        logic [7:0] b, x;

        #1 check_reset_vals();
        @(negedge clock);
        #2 reset = 1'b1;
        @(negedge clock);

        // Basic load
        basic = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                  8'h01, 8'h08, 8'h40, 8'h20, 8'h44};
        run_image(basic, 0);
        if (wq.size() == 2) begin
            check("basic_w0", wq[0].data, 32'h20080005);
            check("basic_w1", wq[1].data, 32'h01084020);
        end

        // Bad checksum, trailing byte must be refused
        do_reset();
        img = basic;
        img[10] = 8'h45;
        img.push_back(8'h11);
        run_image(img, 0);

        // Empty image, good and bad checksum
        do_reset();
        img = '{8'h00, 8'h00, 8'h00, 8'h55};
        run_image(img, 0);
        do_reset();
        img = '{8'h00, 8'h00, 8'h07};
        run_image(img, 0);

        // Oversize count
        do_reset();
        img = '{8'h01, 8'h01, 8'haa, 8'hbb};
        run_image(img, 0);

        // Full-capacity image (256 words)
        do_reset();
        img = '{8'h01, 8'h00};
        x = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            b = 8'($urandom);
            img.push_back(b);
            x ^= b;
        end
        img.push_back(x);
        run_image(img, 0);

        // Gapped basic load
        do_reset();
        run_image(basic, 5);

        // Random images, some with corrupted checksums
        for (int t = 0; t < 6; t++) begin
            do_reset();
            n = int'($urandom_range(1, 6));
            img = '{8'(n >> 8), 8'(n)};
            x = 8'h00;
            for (int i = 0; i < 4 * n; i++) begin
                b = 8'($urandom);
                img.push_back(b);
                x ^= b;
            end
            if ($urandom_range(0, 1) == 1) x ^= 8'h01;
            img.push_back(x);
            img.push_back(8'($urandom));
            run_image(img, 3);
        end

        // Reset after 6 payload bytes, then a full reload
        do_reset();
        drive(basic, 0, 8);
        do_reset();
        run_image(basic, 0);

        // Reset during a pending write strobe, then a full reload
        do_reset();
        drive(basic, 0, 6);
        check("we_pending", imem_we, 1'b1);
        do_reset();
        run_image(basic, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
